// File: rtl/ns3_capture_pkg.sv
// Shared constants for the capture sequencer: state codes and the default
// sample RAM address width.
package ns3_capture_pkg;

  localparam int ADDR_W_DEFAULT = 13;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_PRE  = ST_PRE,
    S_WAIT = ST_WAIT,
    S_POST = ST_POST,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/capture_addr_counter.sv
// Wrapping write-address counter for the sample RAM; clear wins over increment.
module capture_addr_counter #(
  parameter int W = 13
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/capture_sequencer.sv
// Acquisition sequencer: runs the decimator, writes decimated samples into the
// wrapping sample RAM, and tracks pre-trigger fill, trigger and post-trigger count.
module capture_sequencer
  import ns3_capture_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Stop,
  input  logic [ADDR_W-1:0] Pretrig_Len,
  input  logic [ADDR_W-1:0] Posttrig_Len,
  input  logic              Trig_Event,
  input  logic              Force_Trig,
  input  logic              Sample_EN,
  output logic              Start_WR,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_Addr,
  output logic [ADDR_W-1:0] Trig_Addr,
  output logic              Busy,
  output logic              Done,
  output logic [2:0]        State
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pre_len_q, pre_len_d;
  logic [ADDR_W-1:0] post_len_q, post_len_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              start_wr_q, start_wr_d;
  logic              busy;
  logic              wr_fire;
  logic              addr_clr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] post_cnt_inc;

  assign busy = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  // A write never lands in a reset or abort cycle, so the address pointer stays consistent.
  assign wr_fire      = Sample_EN && busy && !Stop && !RST;
  assign post_cnt_inc = post_cnt_q + ADDR_W'(1);

  // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    pre_len_d   = pre_len_q;
    post_len_d  = post_len_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    addr_clr    = 1'b0;

    if (Stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_d    = S_PRE;
            addr_clr   = 1'b1;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            pre_len_d  = Pretrig_Len;
            post_len_d = Posttrig_Len;
          end
        end
        S_PRE: begin
          if (pre_cnt_q == pre_len_q) begin
            state_d = S_WAIT;
          end else if (wr_fire) begin
            pre_cnt_d = pre_cnt_q + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          if (Trig_Event || Force_Trig) begin
            trig_addr_d = wr_addr;
            post_cnt_d  = wr_fire ? ADDR_W'(1) : '0;
            if ((post_len_q == '0) || (wr_fire && (post_len_q <= ADDR_W'(1)))) begin
              state_d = S_DONE;
            end else begin
              state_d = S_POST;
            end
          end
        end
        S_POST: begin
          if (wr_fire) begin
            post_cnt_d = post_cnt_inc;
            if (post_cnt_inc == post_len_q) begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    start_wr_d = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pre_len_q   <= '0;
      post_len_q  <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      start_wr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_len_q   <= pre_len_d;
      post_len_q  <= post_len_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      start_wr_q  <= start_wr_d;
    end
  end

  capture_addr_counter #(
    .W(ADDR_W)
  ) u_addr (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (addr_clr),
    .inc_i  (wr_fire),
    .count_o(wr_addr)
  );

  assign Start_WR  = start_wr_q;
  assign WR_EN     = wr_fire;
  assign WR_Addr   = wr_addr;
  assign Trig_Addr = trig_addr_q;
  assign Busy      = busy;
  assign Done      = (state_q == S_DONE);
  assign State     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer with ADDR_W=4: expected write
// addresses are queued as samples are driven and checked as the DUT writes.
module tb_capture_sequencer;

  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST, Start, Stop, Trig_Event, Force_Trig, Sample_EN;
  logic [AW-1:0] Pretrig_Len, Posttrig_Len;
  logic          Start_WR, WR_EN, Busy, Done;
  logic [AW-1:0] WR_Addr, Trig_Addr;
  logic [2:0]    State;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 CLK = ~CLK;

  capture_sequencer #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Stop(Stop),
    .Pretrig_Len(Pretrig_Len), .Posttrig_Len(Posttrig_Len),
    .Trig_Event(Trig_Event), .Force_Trig(Force_Trig), .Sample_EN(Sample_EN),
    .Start_WR(Start_WR), .WR_EN(WR_EN), .WR_Addr(WR_Addr), .Trig_Addr(Trig_Addr),
    .Busy(Busy), .Done(Done), .State(State)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every observed write pops the next expected address.
  always @(negedge CLK) begin
    if (WR_EN === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(WR_Addr), 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", 32'(WR_Addr), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One sample strobe followed by two idle cycles (decimate by 3).
  task automatic do_write(input int addr);
    exp_q.push_back(addr);
    Sample_EN = 1'b1;
    tick();
    Sample_EN = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_trig();
    Trig_Event = 1'b1;
    tick();
    Trig_Event = 1'b0;
  endtask

  task automatic start_capture(input int pre, input int post);
    Pretrig_Len  = AW'(pre);
    Posttrig_Len = AW'(post);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Pretrig_Len  = '1;
    Posttrig_Len = '1;
  endtask

  initial begin
    RST = 1'b1; Start = 1'b0; Stop = 1'b0; Trig_Event = 1'b0; Force_Trig = 1'b0;
    Sample_EN = 1'b0; Pretrig_Len = '0; Posttrig_Len = '0;
    tick(); tick();
    RST = 1'b0;
    tick();
    check("rst_state", 32'(State), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_start_wr", 32'(Start_WR), 0);

    // 1. basic: Pre=3, Post=4, trigger after 5th write
    start_capture(3, 4);
    check("t1_state_pre", 32'(State), 1);
    check("t1_start_wr", 32'(Start_WR), 1);
    for (int i = 0; i < 3; i++) do_write(i);
    check("t1_state_wait", 32'(State), 2);
    for (int i = 3; i < 5; i++) do_write(i);
    pulse_trig();
    check("t1_state_post", 32'(State), 3);
    check("t1_trig_addr", 32'(Trig_Addr), 5);
    for (int i = 5; i < 9; i++) do_write(i);
    check("t1_state_done", 32'(State), 4);
    check("t1_done", 32'(Done), 1);
    check("t1_wr_addr", 32'(WR_Addr), 9);
    check("t1_start_wr_low", 32'(Start_WR), 0);
    check("t1_queue_empty", 32'(exp_q.size()), 0);

    // 2. trigger masked during pre-fill
    start_capture(3, 2);
    do_write(0);
    pulse_trig();
    check("t2_masked", 32'(State), 1);
    do_write(1);
    do_write(2);
    check("t2_state_wait", 32'(State), 2);
    pulse_trig();
    check("t2_state_post", 32'(State), 3);
    check("t2_trig_addr", 32'(Trig_Addr), 3);
    do_write(3);
    do_write(4);
    check("t2_state_done", 32'(State), 4);
    check("t2_wr_addr", 32'(WR_Addr), 5);

    // 3. address wrap: trigger after write 20
    start_capture(2, 2);
    for (int i = 0; i < 16; i++) do_write(i);
    check("t3_wrap", 32'(WR_Addr), 0);
    for (int i = 16; i < 20; i++) do_write(i % 16);
    pulse_trig();
    check("t3_trig_addr", 32'(Trig_Addr), 4);
    do_write(4);
    do_write(5);
    check("t3_state_done", 32'(State), 4);
    check("t3_wr_addr", 32'(WR_Addr), 6);

    // 4. Stop beats a simultaneous trigger
    start_capture(0, 5);
    tick();
    check("t4_state_wait", 32'(State), 2);
    do_write(0);
    Stop = 1'b1; Trig_Event = 1'b1;
    tick();
    Stop = 1'b0; Trig_Event = 1'b0;
    check("t4_state_idle", 32'(State), 0);
    check("t4_trig_addr_held", 32'(Trig_Addr), 4);
    check("t4_start_wr", 32'(Start_WR), 0);
    check("t4_wr_addr_held", 32'(WR_Addr), 1);

    // 5. zero lengths, then Start ignored in POST
    start_capture(0, 0);
    check("t5_state_pre", 32'(State), 1);
    tick();
    check("t5_state_wait", 32'(State), 2);
    Force_Trig = 1'b1;
    tick();
    Force_Trig = 1'b0;
    check("t5_state_done", 32'(State), 4);
    check("t5_wr_addr", 32'(WR_Addr), 0);
    check("t5_trig_addr", 32'(Trig_Addr), 0);
    start_capture(0, 3);
    tick();
    Force_Trig = 1'b1;
    tick();
    Force_Trig = 1'b0;
    check("t5_state_post", 32'(State), 3);
    do_write(0);
    start_capture(7, 7);
    check("t5_start_ignored", 32'(State), 3);
    do_write(1);
    check("t5_still_post", 32'(State), 3);
    check("t5_wr_addr_post", 32'(WR_Addr), 2);

    // 6. reset in POST, with a strobe during reset that must not write
    RST = 1'b1; Sample_EN = 1'b1;
    tick();
    Sample_EN = 1'b0;
    tick();
    RST = 1'b0;
    check("t6_state", 32'(State), 0);
    check("t6_start_wr", 32'(Start_WR), 0);
    check("t6_wr_en", 32'(WR_EN), 0);
    check("t6_done", 32'(Done), 0);
    check("t6_wr_addr", 32'(WR_Addr), 0);
    check("t6_trig_addr", 32'(Trig_Addr), 0);
    check("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
